hex_rx_decoder: RTL and testbench

HEX_RX_DECODER -- requirements
Module: hex_rx_decoder

---
 rtl/hex_rx_decoder_pkg.sv | 28 ++
 rtl/hex_rx_decoder_ascii_to_nibble.sv | 37 +++
 rtl/hex_rx_decoder.sv | 137 +++++++++++++
 tb/tb_hex_rx_decoder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_rx_decoder_pkg.sv
// hex_defs: shared definitions for the ASCII-hex receive decoder.
// Holds the separator character codes, the two-state decoder encoding
// and a helper that recognises separator characters.
package hex_defs;

  // Separator characters that delimit hex values in the input stream
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_COMMA = 8'h2C;

  // Decoder state: WAIT_LO means a high nibble is held
  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } state_t;

  // True when the character is one of the separators above
  function automatic logic is_sep_char(input logic [7:0] c);
    logic r;
    case (c)
      CH_SPACE, CH_CR, CH_LF, CH_COMMA: r = 1'b1;
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hex_rx_decoder_ascii_to_nibble.sv
// ascii_to_nibble: combinational classifier for one ASCII character.
// Inverse of the nibble-to-ASCII converter; accepts both letter cases.
// Ports:
//   in[7:0]     ASCII character
//   is_digit    1 for '0'-'9', 'A'-'F', 'a'-'f'
//   is_sep      1 for space, CR, LF, comma
//   nibble[3:0] digit value (0 when not a digit)
module ascii_to_nibble
  import hex_defs::*;
(
  input  logic [7:0] in,
  output logic       is_digit,
  output logic       is_sep,
  output logic [3:0] nibble
);

  // Classify the character and derive its hex value
  always_comb begin
    is_digit = 1'b0;
    is_sep   = 1'b0;
    nibble   = 4'h0;
    if ((in >= 8'h30) && (in <= 8'h39)) begin
      is_digit = 1'b1;
      nibble   = in[3:0];
    end else if (((in >= 8'h41) && (in <= 8'h46)) ||
                 ((in >= 8'h61) && (in <= 8'h66))) begin
      // Letters A-F / a-f have low nibble 1..6; adding 9 gives 10..15
      is_digit = 1'b1;
      nibble   = in[3:0] + 4'h9;
    end else if (is_sep_char(in)) begin
      is_sep = 1'b1;
    end else begin
      is_sep = 1'b0;
    end
  end

endmodule

// File: rtl/hex_rx_decoder.sv
// hex_rx_decoder: turns a stream of ASCII hex characters into bytes.
// Two digits form a byte {hi,lo}; a lone digit followed by a separator
// forms {4'h0,hi}. Completed bytes sit in a one-entry holding register.
// Ports:
//   clk, resetn   clock and asynchronous active-low reset
//   rx_valid      one-cycle pulse, rx_data holds a character
//   rx_data[7:0]  received ASCII character
//   byte_ready    consumer accepts the held byte
//   byte_valid    holding register full
//   byte_data     decoded byte
//   hi_pending    high nibble stored, waiting for the second digit
//   err_char      one-cycle pulse on an illegal character
//   err_overrun   one-cycle pulse when a completed byte is dropped
module hex_rx_decoder
  import hex_defs::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       byte_ready,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       hi_pending,
  output logic       err_char,
  output logic       err_overrun
);

  state_t     state_r, state_s;
  logic [3:0] hi_r, hi_s;
  logic       byte_valid_r, byte_valid_s;
  logic [7:0] byte_data_r, byte_data_s;
  logic       err_char_r, err_char_s;
  logic       err_overrun_r, err_overrun_s;

  logic       is_digit_s;
  logic       is_sep_s;
  logic [3:0] nibble_s;
  logic       complete_s;
  logic [7:0] new_byte_s;
  logic       accept_s;

  ascii_to_nibble u_cls (
    .in       (rx_data),
    .is_digit (is_digit_s),
    .is_sep   (is_sep_s),
    .nibble   (nibble_s)
  );

  // Next-state logic: decoder FSM, byte completion and holding register
  always_comb begin
    state_s       = state_r;
    hi_s          = hi_r;
    complete_s    = 1'b0;
    new_byte_s    = 8'h00;
    err_char_s    = 1'b0;
    err_overrun_s = 1'b0;
    byte_valid_s  = byte_valid_r;
    byte_data_s   = byte_data_r;
    accept_s      = byte_valid_r & byte_ready;

    if (rx_valid) begin
      case (state_r)
        WAIT_HI: begin
          if (is_digit_s) begin
            hi_s    = nibble_s;
            state_s = WAIT_LO;
          end else if (is_sep_s) begin
            state_s = WAIT_HI;
          end else begin
            err_char_s = 1'b1;
            state_s    = WAIT_HI;
          end
        end
        WAIT_LO: begin
          state_s = WAIT_HI;
          if (is_digit_s) begin
            complete_s = 1'b1;
            new_byte_s = {hi_r, nibble_s};
          end else if (is_sep_s) begin
            complete_s = 1'b1;
            new_byte_s = {4'h0, hi_r};
          end else begin
            err_char_s = 1'b1;
            hi_s       = 4'h0;
          end
        end
        default: begin
          state_s = WAIT_HI;
          hi_s    = 4'h0;
        end
      endcase
    end else begin
      state_s = state_r;
    end

    // A slot is free if empty or being drained this cycle
    if (complete_s) begin
      if (!byte_valid_r || accept_s) begin
        byte_valid_s = 1'b1;
        byte_data_s  = new_byte_s;
      end else begin
        err_overrun_s = 1'b1;
      end
    end else if (accept_s) begin
      byte_valid_s = 1'b0;
    end else begin
      byte_valid_s = byte_valid_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r       <= WAIT_HI;
      hi_r          <= 4'h0;
      byte_valid_r  <= 1'b0;
      byte_data_r   <= 8'h00;
      err_char_r    <= 1'b0;
      err_overrun_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      hi_r          <= hi_s;
      byte_valid_r  <= byte_valid_s;
      byte_data_r   <= byte_data_s;
      err_char_r    <= err_char_s;
      err_overrun_r <= err_overrun_s;
    end
  end

  assign byte_valid  = byte_valid_r;
  assign byte_data   = byte_data_r;
  assign hi_pending  = (state_r == WAIT_LO);
  assign err_char    = err_char_r;
  assign err_overrun = err_overrun_r;

endmodule

// File: tb/tb_hex_rx_decoder.sv
// Self-checking bench for hex_rx_decoder: directed scenarios followed by
// randomized character streams, compared against a behavioural model.
module tb_hex_rx_decoder;

  logic       clk;
  logic       resetn;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       byte_ready;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       hi_pending;
  logic       err_char;
  logic       err_overrun;

  int checks_cnt;
  int errors_cnt;

  // Reference model state: pending nibble (-1 when none) and holding slot
  int         m_pending;
  logic       m_bv;
  logic [7:0] m_bd;
  logic       m_ec;
  logic       m_eo;

  hex_rx_decoder dut (
    .clk         (clk),
    .resetn      (resetn),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .byte_ready  (byte_ready),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .hi_pending  (hi_pending),
    .err_char    (err_char),
    .err_overrun (err_overrun)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Character value: 0..15 digit, -1 separator, -2 illegal
  function automatic int char_val(input logic [7:0] c);
    int v;
    v = int'(c);
    if (v >= 48 && v <= 57)  return v - 48;
    if (v >= 65 && v <= 70)  return v - 65 + 10;
    if (v >= 97 && v <= 102) return v - 97 + 10;
    if (v == 32 || v == 13 || v == 10 || v == 44) return -1;
    return -2;
  endfunction

  task automatic model_reset();
    m_pending = -1;
    m_bv = 1'b0;
    m_bd = 8'h00;
    m_ec = 1'b0;
    m_eo = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".byte_valid"},  32'(byte_valid),  32'(m_bv));
    check_eq({tag, ".byte_data"},   32'(byte_data),   32'(m_bd));
    check_eq({tag, ".hi_pending"},  32'(hi_pending),  32'(m_pending >= 0));
    check_eq({tag, ".err_char"},    32'(err_char),    32'(m_ec));
    check_eq({tag, ".err_overrun"}, 32'(err_overrun), 32'(m_eo));
  endtask

  // One clock: drive inputs, advance the model, compare after the edge
  task automatic step(input logic rv, input logic [7:0] ch, input logic rdy, input string tag);
    int  v;
    int  produced;
    logic taken;
    @(negedge clk);
    rx_valid   = rv;
    rx_data    = ch;
    byte_ready = rdy;
    taken    = m_bv && rdy;
    produced = -1;
    m_ec = 1'b0;
    m_eo = 1'b0;
    if (rv) begin
      v = char_val(ch);
      if (m_pending < 0) begin
        if (v >= 0) m_pending = v;
        else if (v == -2) m_ec = 1'b1;
      end else begin
        if (v >= 0) produced = m_pending * 16 + v;
        else if (v == -1) produced = m_pending;
        else m_ec = 1'b1;
        m_pending = -1;
      end
    end
    if (produced >= 0) begin
      if (!m_bv || taken) begin
        m_bv = 1'b1;
        m_bd = 8'(produced);
      end else begin
        m_eo = 1'b1;
      end
    end else if (taken) begin
      m_bv = 1'b0;
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    compare_all(tag);
  endtask

  task automatic send(input logic [7:0] ch, input logic rdy);
    step(1'b1, ch, rdy, "chr");
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 8'h00, rdy, "idle");
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    resetn = 1'b0;
    #2;
    model_reset();
    compare_all("rst");
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    logic [7:0] digits [16];
    checks_cnt = 0;
    errors_cnt = 0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    byte_ready = 1'b1;
    resetn     = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) digits[i] = 8'(48 + i);
    for (int i = 10; i < 16; i++) digits[i] = 8'(55 + i);
    #12;
    compare_all("rst0");
    resetn = 1'b1;

    // "4","1" -> 0x41, hi_pending between characters
    send("4", 1'b1);
    check_eq("d41.hi_pending", 32'(hi_pending), 32'd1);
    send("1", 1'b0);
    check_eq("d41.data", 32'(byte_data), 32'h41);
    check_eq("d41.valid", 32'(byte_valid), 32'd1);
    idle(1'b1);
    check_eq("d41.drained", 32'(byte_valid), 32'd0);

    // Leading LF, "a","F",CR -> 0xAF; "7",space -> 0x07
    send(8'h0A, 1'b1);
    send("a", 1'b1);
    send("F", 1'b1);
    check_eq("dAF.data", 32'(byte_data), 32'hAF);
    send(8'h0D, 1'b1);
    send("7", 1'b1);
    send(8'h20, 1'b1);
    check_eq("d07.data", 32'(byte_data), 32'h07);
    idle(1'b1);

    // "3","G" -> err_char, no byte; "0","0" -> 0x00
    send("3", 1'b1);
    send("G", 1'b1);
    check_eq("dG.err_char", 32'(err_char), 32'd1);
    check_eq("dG.hi_pending", 32'(hi_pending), 32'd0);
    idle(1'b1);
    check_eq("dG.err_clear", 32'(err_char), 32'd0);
    send("0", 1'b1);
    send("0", 1'b1);
    check_eq("d00.data", 32'(byte_data), 32'h00);
    idle(1'b1);

    // Overrun: hold 0x12, then "34" is dropped
    send("1", 1'b0);
    send("2", 1'b0);
    send("3", 1'b0);
    send("4", 1'b0);
    check_eq("ovr.pulse", 32'(err_overrun), 32'd1);
    check_eq("ovr.kept", 32'(byte_data), 32'h12);
    idle(1'b0);
    idle(1'b1);
    check_eq("ovr.consumed", 32'(byte_valid), 32'd0);

    // Accept and complete in the same cycle
    send("1", 1'b0);
    send("2", 1'b0);
    send("3", 1'b0);
    send("4", 1'b1);
    check_eq("same.data", 32'(byte_data), 32'h34);
    check_eq("same.valid", 32'(byte_valid), 32'd1);
    check_eq("same.no_ovr", 32'(err_overrun), 32'd0);
    idle(1'b1);

    // Reset mid-WAIT_LO with a full holding register
    send("9", 1'b0);
    send("9", 1'b0);
    send("5", 1'b0);
    pulse_reset();
    send("6", 1'b1);
    send("7", 1'b0);
    check_eq("rst.data", 32'(byte_data), 32'h67);
    idle(1'b1);

    // Randomized streams
    for (int n = 0; n < 3000; n++) begin
      int sel;
      logic [7:0] ch;
      sel = int'($urandom_range(0, 99));
      if (sel < 55) begin
        ch = digits[$urandom_range(0, 15)];
        if ($urandom_range(0, 1) == 1 && ch >= 8'h41) ch = ch + 8'h20;
      end else if (sel < 75) begin
        case ($urandom_range(0, 3))
          0:       ch = 8'h20;
          1:       ch = 8'h0D;
          2:       ch = 8'h0A;
          default: ch = 8'h2C;
        endcase
      end else begin
        ch = 8'($urandom_range(0, 255));
      end
      if (n % 700 == 350) pulse_reset();
      step(($urandom_range(0, 9) < 7), ch, ($urandom_range(0, 1) == 1), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
